// File: rtl/chunked_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : chunked_adder_sequencer
// Purpose  : Multi-cycle WIDTH-bit adder. Operands are captured on a
//            valid/ready handshake and summed one CHUNK-bit ripple slice per
//            clock, low slice first, with the inter-slice carry held in a
//            register. The result is held until the consumer takes it.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid / in_ready - operand handshake (a, b, sub)
//            a, b                - WIDTH-bit operands
//            sub                 - a-b select (present only with SUBTRACT_EN)
//            out_valid/out_ready - result handshake
//            sum, carry_out      - registered result and top-slice carry
//            busy                - high while computing or holding a result
// Options  : `define SUBTRACT_EN adds the sub port and a-b support.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_adder_sequencer #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               carry_out_q, carry_out_d;

   logic               sub_sel;
   logic [CHUNK-1:0]   slice_a;
   logic [CHUNK-1:0]   slice_b;
   logic [CHUNK:0]     slice_res;

`ifdef SUBTRACT_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   // Pure state decodes; rst masks in_ready so nothing is offered while the
   // block is being reset.
   assign in_ready  = (state_q == ST_IDLE) && !rst;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      slice_a     = '0;
      slice_b     = '0;

      // Select the active slice of the latched operands.
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == i[IDX_W-1:0]) begin
            slice_a = a_q[i*CHUNK +: CHUNK];
            slice_b = b_q[i*CHUNK +: CHUNK];
         end
      end

      // The single CHUNK-bit adder shared by every slice.
      slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};

      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               // Subtraction is a + ~b + 1: invert b, seed the carry with 1.
               a_d     = a;
               b_d     = sub_sel ? ~b : b;
               carry_d = sub_sel;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            carry_d = slice_res[CHUNK];
            for (int i = 0; i < NCHUNK; i++) begin
               if (idx_q == i[IDX_W-1:0]) begin
                  sum_d[i*CHUNK +: CHUNK] = slice_res[CHUNK-1:0];
               end
            end
            if (idx_q == LAST_IDX) begin
               carry_out_d = slice_res[CHUNK];
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_adder_sequencer
// Purpose  : Self-checking bench for chunked_adder_sequencer. A 32/8 instance
//            is compared every cycle against an arithmetic reference model
//            (result = a+b or a-b, ready NCHUNK cycles after accept), under
//            directed and random traffic. An 8/8 instance covers NCHUNK=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_adder_sequencer;

   localparam int W = 32;
   localparam int C = 8;
   localparam int N = W / C;
`ifdef SUBTRACT_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, out_ready, sub;
   logic [W-1:0]  a, b;
   logic          in_ready, out_valid, carry_out, busy;
   logic [W-1:0]  sum;

   logic          in_valid8, out_ready8, sub8;
   logic [7:0]    a8, b8;
   logic          in_ready8, out_valid8, carry_out8, busy8;
   logic [7:0]    sum8;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   chunked_adder_sequencer #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
`ifdef SUBTRACT_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carry_out(carry_out), .busy(busy)
   );

   chunked_adder_sequencer #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8),
`ifdef SUBTRACT_EN
      .sub(sub8),
`endif
      .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8),
      .carry_out(carry_out8), .busy(busy8)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (arithmetic level) ----------------
   bit           m_has  = 1'b0;   // a result is being computed or held
   int           m_age  = 0;      // edges since accept, saturating at N
   logic [W:0]   m_res  = '0;     // {carry_out, sum}
   bit           m_zero = 1'b0;   // outputs known cleared by reset
   logic         sub_eff;

   assign sub_eff = HAS_SUB && sub;

   always @(posedge clk) begin
      if (rst) begin
         m_has  <= 1'b0;
         m_age  <= 0;
         m_zero <= 1'b1;
      end else if (!m_has && in_valid) begin
         m_has  <= 1'b1;
         m_age  <= 0;
         m_zero <= 1'b0;
         m_res  <= sub_eff ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
      end else if (m_has) begin
         if (m_age >= N && out_ready) m_has <= 1'b0;
         else if (m_age < N)          m_age <= m_age + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      logic exp_ov;
      #1;
      exp_ov = m_has && (m_age >= N);
      chk("in_ready",  in_ready,  !m_has && !rst);
      chk("out_valid", out_valid, exp_ov);
      chk("busy",      busy,      m_has);
      if (exp_ov) begin
         chk("sum",       sum,       m_res[W-1:0]);
         chk("carry_out", carry_out, m_res[W]);
      end
      if (m_zero) begin
         chk("reset_sum", {carry_out, sum}, '0);
      end
   end

   // Issue one op to the idle 32-bit instance, hold the result for 'hold'
   // cycles (offering ignored operands meanwhile), pin it against literals.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input int hold, input logic [W-1:0] es, input logic ec,
                         input string nm);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a = ta; b = tb_v; sub = ts;
      @(negedge clk);
      in_valid = (hold > 0);
      a = $urandom; b = $urandom;
      repeat (N) @(negedge clk);
      #2;
      chk({nm, "_valid"}, out_valid, 1'b1);
      chk({nm, "_sum"},   sum,       es);
      chk({nm, "_co"},    carry_out, ec);
      chk({nm, "_model"}, m_res,     {ec, es});
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         #2;
         chk({nm, "_held"}, {out_valid, carry_out, sum}, {1'b1, ec, es});
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Carry out of slice 0 only, then a carry crossing every slice.
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 32'h0000_0100, 1'b0, "ff_plus_1");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1, "wrap");
      // Backpressure, then an immediate back-to-back op.
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 5, 32'h2345_6789, 1'b0, "hold");
      run_op(32'h8000_0000, 32'h8000_0001, 1'b0, 0, 32'h0000_0001, 1'b1, "after_hold");

      // Reset after two RUN cycles discards the op.
      in_valid = 1'b1; a = 32'd1; b = 32'd2;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("rst_mid_run", {in_ready, out_valid, busy, carry_out, sum}, {3'b100, 1'b0, 32'd0});
      @(negedge clk);
      run_op(32'd3, 32'd4, 1'b0, 0, 32'd7, 1'b0, "post_rst");

`ifdef SUBTRACT_EN
      run_op(32'd5, 32'd7, 1'b1, 0, 32'hFFFF_FFFE, 1'b0, "sub_5_7");
      run_op(32'd7, 32'd5, 1'b1, 0, 32'h0000_0002, 1'b1, "sub_7_5");
`endif

      // NCHUNK = 1 instance: result one cycle after accept.
      in_valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h20;
      @(negedge clk);
      in_valid8 = 1'b0;
      #2;
      chk("n1_run", {out_valid8, in_ready8, busy8}, 3'b001);
      @(negedge clk);
      #2;
      chk("n1_done", {out_valid8, carry_out8, sum8}, {2'b11, 8'h10});
      out_ready8 = 1'b1;
      @(negedge clk);
      out_ready8 = 1'b0;
      #2;
      chk("n1_idle", {in_ready8, out_valid8}, 2'b10);

      // Random traffic checked by the model every cycle.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 59) == 0);
         in_valid  = $urandom_range(0, 1);
         out_ready = ($urandom_range(0, 2) != 0);
         sub       = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       a = 32'hFFFF_FFFF;
            1:       a = 32'd0;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0:       b = 32'h0000_0001;
            1:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
      end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
